prng_burst_engine: RTL and testbench

Parametrised successor to the coprocessor PRNG block. It is a Galois LFSR engine with configurable width, taps and rounds per output word. It generates a burst of `burstLen` words under start/abort control and delivers them over a valid/ready stream. Its status vector drops straight into a CSR update path, using the same done/busy encoding the existing CSRs use.

---
 rtl/prng_pkg.sv | 21 ++
 rtl/prng_lfsr_core.sv | 37 +++
 rtl/prng_burst_engine.sv | 219 +++++++++++++++++++++
 tb/tb_prng_burst_engine.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/prng_pkg.sv
// Shared types and constants for the PRNG burst engine.
//   - prng_state_e : FSM states (IDLE, RUN, PRESENT)
//   - STATUS_*     : bit positions inside the {error, busy, done} status vector
//   - TAPS_128     : Galois right-shift mask for x^128+x^126+x^101+x^99+1
package prng_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PRESENT = 2'd2
    } prng_state_e;

    localparam int unsigned STATUS_DONE  = 0;
    localparam int unsigned STATUS_BUSY  = 1;
    localparam int unsigned STATUS_ERROR = 2;
    localparam int unsigned STATUS_W     = 3;

    // Exponent k of the polynomial maps to mask bit k-1 (bits 127, 125, 100, 98).
    localparam logic [127:0] TAPS_128 = 128'hA0000014_00000000_00000000_00000000;

endpackage

// File: rtl/prng_lfsr_core.sv
// Galois LFSR register with load and step controls.
// Ports:
//   clock, resetN     : clock and synchronous active-low reset (state <= INIT)
//   load, load_value  : replace the state with load_value (wins over step)
//   step              : advance the state by one Galois right-shift step
//   state             : current LFSR state (registered)
//   next_c            : combinational one-step successor of state
module prng_lfsr_core #(
    parameter int unsigned      WIDTH = 128,
    parameter logic [WIDTH-1:0] TAPS  = '0,
    parameter logic [WIDTH-1:0] INIT  = WIDTH'(1)
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             step,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next_c
);

    // s' = (s >> 1) ^ (s[0] ? TAPS : 0)
    always_comb begin
        next_c = (state >> 1) ^ (state[0] ? TAPS : '0);
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state <= INIT;
        end else if (load) begin
            state <= load_value;
        end else if (step) begin
            state <= next_c;
        end
    end

endmodule

// File: rtl/prng_burst_engine.sv
// Burst PRNG engine: runs ROUNDS LFSR steps per word and streams burstLen
// words over a valid/ready interface, with start/abort control.
// Optional build macro: PRNG_HEALTH_EN (reject repeated or all-zero words).
// Ports:
//   clock, resetN         : clock and synchronous active-low reset
//   start, loadSeed, seed : burst request; optional seed load (IDLE only)
//   burstLen              : words per burst, latched on an accepted start
//   abort                 : terminate the burst (highest priority)
//   outData/outValid/outReady : output word stream
//   status                : {error, busy, done}
//   wordCount             : words transferred in the current or last burst
module prng_burst_engine
    import prng_pkg::*;
#(
    parameter int unsigned      WIDTH   = 128,
    parameter logic [WIDTH-1:0] TAPS    = WIDTH'(prng_pkg::TAPS_128),
    parameter int unsigned      ROUNDS  = 8,
    parameter int unsigned      BURST_W = 8,
    parameter logic [WIDTH-1:0] INIT    = WIDTH'(1)
) (
    input  logic                clock,
    input  logic                resetN,
    input  logic                start,
    input  logic                loadSeed,
    input  logic [WIDTH-1:0]    seed,
    input  logic [BURST_W-1:0]  burstLen,
    input  logic                abort,
    output logic [WIDTH-1:0]    outData,
    output logic                outValid,
    input  logic                outReady,
    output logic [STATUS_W-1:0] status,
    output logic [BURST_W-1:0]  wordCount
);

    localparam int unsigned    RND_W      = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [RND_W-1:0] ROUND_LAST = RND_W'(ROUNDS - 1);

    prng_state_e        state, state_nx;
    logic [RND_W-1:0]   round_cnt, round_nx;
    logic [BURST_W-1:0] count, count_nx, count_inc;
    logic [BURST_W-1:0] len_q, len_nx;
    logic [WIDTH-1:0]   data_nx;
    logic               valid_nx;
    logic               done_q, done_nx;
    logic               busy_q, busy_nx;
    logic               err_q, err_nx;
    logic               health_fail_c;

    logic               lfsr_load, lfsr_step;
    logic [WIDTH-1:0]   lfsr_state, lfsr_next_c;

`ifdef PRNG_HEALTH_EN
    logic [WIDTH-1:0]   prev_word, prev_nx;
    logic               prev_vld, prev_vld_nx;
`endif

    prng_lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .INIT  (INIT)
    ) u_lfsr (
        .clock      (clock),
        .resetN     (resetN),
        .load       (lfsr_load),
        .load_value (seed),
        .step       (lfsr_step),
        .state      (lfsr_state),
        .next_c     (lfsr_next_c)
    );

    assign count_inc = count + BURST_W'(1);

    // Next-state, LFSR control and output updates
    always_comb begin
        state_nx      = state;
        round_nx      = round_cnt;
        count_nx      = count;
        len_nx        = len_q;
        data_nx       = outData;
        valid_nx      = outValid;
        done_nx       = done_q;
        busy_nx       = busy_q;
        err_nx        = err_q;
        lfsr_load     = 1'b0;
        lfsr_step     = 1'b0;
        health_fail_c = 1'b0;
`ifdef PRNG_HEALTH_EN
        prev_nx       = prev_word;
        prev_vld_nx   = prev_vld;
`endif

        if (abort) begin
            // Abort wins over start, capture and transfer; LFSR and count hold.
            state_nx = IDLE;
            valid_nx = 1'b0;
            busy_nx  = 1'b0;
            done_nx  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        done_nx  = 1'b0;
                        err_nx   = 1'b0;
                        count_nx = '0;
                        len_nx   = burstLen;
                        if (loadSeed && (seed == '0)) begin
                            err_nx = 1'b1;
                        end else begin
                            lfsr_load = loadSeed;
                            round_nx  = '0;
`ifdef PRNG_HEALTH_EN
                            prev_vld_nx = 1'b0;
`endif
                            if (burstLen == '0) begin
                                done_nx = 1'b1;
                            end else begin
                                busy_nx  = 1'b1;
                                state_nx = RUN;
                            end
                        end
                    end
                end

                RUN: begin
                    lfsr_step = 1'b1;
                    if (round_cnt == ROUND_LAST) begin
`ifdef PRNG_HEALTH_EN
                        health_fail_c = (lfsr_next_c == '0) ||
                                        (prev_vld && (lfsr_next_c == prev_word));
                        prev_nx       = lfsr_next_c;
                        prev_vld_nx   = 1'b1;
`endif
                        if (health_fail_c) begin
                            err_nx   = 1'b1;
                            busy_nx  = 1'b0;
                            done_nx  = 1'b0;
                            state_nx = IDLE;
                        end else begin
                            data_nx  = lfsr_next_c;
                            valid_nx = 1'b1;
                            state_nx = PRESENT;
                        end
                    end else begin
                        round_nx = round_cnt + RND_W'(1);
                    end
                end

                PRESENT: begin
                    if (outReady) begin
                        count_nx = count_inc;
                        valid_nx = 1'b0;
                        round_nx = '0;
                        if (count_inc == len_q) begin
                            busy_nx  = 1'b0;
                            done_nx  = 1'b1;
                            state_nx = IDLE;
                        end else begin
                            state_nx = RUN;
                        end
                    end
                end

                default: begin
                    state_nx = IDLE;
                    valid_nx = 1'b0;
                    busy_nx  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (!resetN) begin
            state     <= IDLE;
            round_cnt <= '0;
            count     <= '0;
            len_q     <= '0;
            outData   <= '0;
            outValid  <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nx;
            round_cnt <= round_nx;
            count     <= count_nx;
            len_q     <= len_nx;
            outData   <= data_nx;
            outValid  <= valid_nx;
            done_q    <= done_nx;
            busy_q    <= busy_nx;
            err_q     <= err_nx;
        end
    end

`ifdef PRNG_HEALTH_EN
    // Previous word of the current burst for the repeat check
    always_ff @(posedge clock) begin
        if (!resetN) begin
            prev_word <= '0;
            prev_vld  <= 1'b0;
        end else begin
            prev_word <= prev_nx;
            prev_vld  <= prev_vld_nx;
        end
    end
`endif

    always_comb begin
        status               = '0;
        status[STATUS_DONE]  = done_q;
        status[STATUS_BUSY]  = busy_q;
        status[STATUS_ERROR] = err_q;
    end

    assign wordCount = count;

endmodule

// File: tb/tb_prng_burst_engine.sv
// Directed self-checking bench for prng_burst_engine (WIDTH=8).
// Instance a: TAPS=8'hB8, ROUNDS=1. Instance b: TAPS=0, ROUNDS=1 (health case).
// Both instances share the same stimulus.
module tb_prng_burst_engine;

    logic       clock = 1'b0;
    logic       resetN;
    logic       start, loadSeed, abort, outReady;
    logic [7:0] seed, burstLen;

    logic [7:0] a_data, b_data;
    logic       a_valid, b_valid;
    logic [2:0] a_status, b_status;
    logic [7:0] a_wc, b_wc;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    prng_burst_engine #(
        .WIDTH(8), .TAPS(8'hB8), .ROUNDS(1), .BURST_W(8), .INIT(8'h01)
    ) dut_a (
        .clock(clock), .resetN(resetN), .start(start), .loadSeed(loadSeed),
        .seed(seed), .burstLen(burstLen), .abort(abort),
        .outData(a_data), .outValid(a_valid), .outReady(outReady),
        .status(a_status), .wordCount(a_wc)
    );

    prng_burst_engine #(
        .WIDTH(8), .TAPS(8'h00), .ROUNDS(1), .BURST_W(8), .INIT(8'h01)
    ) dut_b (
        .clock(clock), .resetN(resetN), .start(start), .loadSeed(loadSeed),
        .seed(seed), .burstLen(burstLen), .abort(abort),
        .outData(b_data), .outValid(b_valid), .outReady(outReady),
        .status(b_status), .wordCount(b_wc)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Wait (bounded) for a word on instance a and check it; does not consume it.
    task automatic get_word(input string tag, input logic [7:0] exp);
        int n = 0;
        while (!a_valid && n < 20) begin
            step();
            n++;
        end
        check({tag, "_valid"}, 16'(a_valid), 16'h1);
        check(tag, 16'(a_data), 16'(exp));
    endtask

    task automatic kick(input logic ld, input logic [7:0] sd, input logic [7:0] len);
        loadSeed = ld;
        seed     = sd;
        burstLen = len;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    initial begin
        resetN = 1'b0; start = 1'b0; loadSeed = 1'b0; abort = 1'b0;
        outReady = 1'b1; seed = 8'h00; burstLen = 8'h00;
        step(); step();
        resetN = 1'b1;
        check("rst_status", 16'(a_status), 16'h0);
        check("rst_valid",  16'(a_valid),  16'h0);
        check("rst_wc",     16'(a_wc),     16'h0);
        check("rst_data",   16'(a_data),   16'h0);

        // Basic burst
        kick(1'b1, 8'h01, 8'd3);
        check("basic_busy",  16'(a_status), 16'h2);
        check("basic_nov1",  16'(a_valid),  16'h0);
        get_word("basic_w1", 8'hB8); step();
        get_word("basic_w2", 8'h5C); step();
        get_word("basic_w3", 8'h2E); step();
        check("basic_done",  16'(a_status), 16'h1);
        check("basic_wc",    16'(a_wc),     16'd3);
        check("basic_novld", 16'(a_valid),  16'h0);

        // Backpressure on word 2
        kick(1'b1, 8'h01, 8'd3);
        get_word("bp_w1", 8'hB8); step();
        outReady = 1'b0;
        get_word("bp_w2", 8'h5C);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_data",  16'(a_data),  16'h5C);
            check("bp_hold_valid", 16'(a_valid), 16'h1);
        end
        outReady = 1'b1;
        step();
        get_word("bp_w3", 8'h2E); step();
        check("bp_done", 16'(a_status), 16'h1);
        check("bp_wc",   16'(a_wc),     16'd3);

        // Zero seed
        kick(1'b1, 8'h00, 8'd3);
        check("zs_status", 16'(a_status), 16'h4);
        for (int i = 0; i < 3; i++) begin
            step();
            check("zs_hold_status", 16'(a_status), 16'h4);
            check("zs_novalid",     16'(a_valid),  16'h0);
        end

        // Abort in PRESENT on word 2, then continue without reseeding
        kick(1'b1, 8'h01, 8'd3);
        get_word("ab_w1", 8'hB8); step();
        outReady = 1'b0;
        get_word("ab_w2", 8'h5C);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("ab_status", 16'(a_status), 16'h0);
        check("ab_wc",     16'(a_wc),     16'd1);
        check("ab_novld",  16'(a_valid),  16'h0);
        outReady = 1'b1;
        kick(1'b0, 8'h00, 8'd1);
        get_word("cont_w1", 8'h2E); step();
        check("cont_done", 16'(a_status), 16'h1);
        check("cont_wc",   16'(a_wc),     16'd1);

        // Burst length 0
        kick(1'b0, 8'h00, 8'd0);
        check("len0_done",  16'(a_status), 16'h1);
        check("len0_novld", 16'(a_valid),  16'h0);
        step();
        check("len0_sticky", 16'(a_status), 16'h1);
        check("len0_novld2", 16'(a_valid),  16'h0);

        // start together with abort: start ignored, done cleared
        abort = 1'b1;
        kick(1'b1, 8'h01, 8'd3);
        abort = 1'b0;
        check("sa_status", 16'(a_status), 16'h0);
        step();
        check("sa_idle",   16'(a_status), 16'h0);
        check("sa_novld",  16'(a_valid),  16'h0);

        // Mid-burst reset
        kick(1'b1, 8'h01, 8'd3);
        step();
        check("mr_pre_valid", 16'(a_valid), 16'h1);
        resetN = 1'b0;
        step();
        resetN = 1'b1;
        check("mr_status", 16'(a_status), 16'h0);
        check("mr_valid",  16'(a_valid),  16'h0);
        check("mr_wc",     16'(a_wc),     16'h0);
        check("mr_data",   16'(a_data),   16'h0);

        // Health scenario on instance b (TAPS=0, seed 02)
        kick(1'b1, 8'h02, 8'd4);
        step();
        check("hl_w1_valid", 16'(b_valid), 16'h1);
        check("hl_w1",       16'(b_data),  16'h01);
        step();
        step();
`ifdef PRNG_HEALTH_EN
        check("hl_err_status", 16'(b_status), 16'h4);
        check("hl_err_novld",  16'(b_valid),  16'h0);
        check("hl_err_wc",     16'(b_wc),     16'd1);
        step();
        check("hl_err_sticky", 16'(b_status), 16'h4);
`else
        check("hl_w2_valid", 16'(b_valid), 16'h1);
        check("hl_w2",       16'(b_data),  16'h00);
        step(); step();
        check("hl_w3_valid", 16'(b_valid), 16'h1);
        check("hl_w3",       16'(b_data),  16'h00);
        step(); step();
        check("hl_w4_valid", 16'(b_valid), 16'h1);
        check("hl_w4",       16'(b_data),  16'h00);
        step();
        check("hl_done", 16'(b_status), 16'h1);
        check("hl_wc",   16'(b_wc),     16'd4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
